// File: rtl/flash_sweep_ctrl.sv
// flash_sweep_ctrl: erase / program / verify sweep controller for the on-board NOR flash.
// Optional ready-wait timeout is compiled in when FLASH_SWEEP_TMO_EN is defined.
module flash_sweep_ctrl #(
  parameter int ADDR_W   = 22,
  parameter int DATA_W   = 16,
  parameter int PROG_DIV = 64,
  parameter int READ_DIV = 16,
  parameter int TMO_CYC  = 1 << 20
) (
  input  logic              iCLK,
  input  logic              iRESET_N,
  input  logic              iCMD_VALID,
  input  logic [1:0]        iCMD,
  output logic              oCMD_READY,
  input  logic [ADDR_W-1:0] iSTART_ADDR,
  input  logic [ADDR_W-1:0] iEND_ADDR,
  input  logic              iABORT,
  input  logic              iFLASH_RY_N,
  input  logic [DATA_W-1:0] iFLASH_DQ,
  input  logic [DATA_W-1:0] iEXP_DQ,
  output logic [ADDR_W-1:0] oFLASH_ADDR,
  output logic [3:0]        oFLASH_CMD,
  output logic              oFLASH_TR,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oFAIL,
  output logic [15:0]       oERR_CNT,
  output logic [ADDR_W-1:0] oERR_ADDR
);

  if (PROG_DIV < 2 || READ_DIV < 2 || TMO_CYC < 1) begin : g_param_check
    $error("flash_sweep_ctrl: PROG_DIV and READ_DIV must be >= 2, TMO_CYC >= 1");
  end

  localparam int DIV_MAX = (PROG_DIV > READ_DIV) ? PROG_DIV : READ_DIV;
  localparam int CNT_W   = $clog2(DIV_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PROG_DIV - 2);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_DIV - 1);

  localparam logic [3:0] FC_READ  = 4'd0;
  localparam logic [3:0] FC_PROG  = 4'd1;
  localparam logic [3:0] FC_ERASE = 4'd4;
  localparam logic [3:0] FC_IDLE  = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_HOLD, S_WAIT_RDY, S_READ, S_NEXT, S_FIN
  } state_t;

  typedef enum logic [1:0] {
    OP_VERIFY  = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_RSVD    = 2'd3
  } op_t;

  state_t            state, state_nxt;
  op_t               op;
  logic [ADDR_W-1:0] addr, end_addr, err_addr;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        flash_cmd;
  logic              fail;
  logic [15:0]       err_cnt;

  logic accept, reject, abort_now, mismatch, at_end;

`ifdef FLASH_SWEEP_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_last;
  assign tmo_last = (tmo_cnt == TMO_LAST);
`endif

  assign accept    = (state == S_IDLE) && iCMD_VALID;
  assign reject    = (iCMD == OP_RSVD) || ((iCMD != OP_ERASE) && (iSTART_ADDR > iEND_ADDR));
  assign abort_now = iABORT && (state != S_IDLE) && (state != S_FIN);
  assign at_end    = (addr == end_addr);
  assign mismatch  = (state == S_READ) && (cnt == READ_LAST) && !iABORT && (iFLASH_DQ != iEXP_DQ);

  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (reject)                  state_nxt = S_FIN;
          else if (iCMD == OP_VERIFY)  state_nxt = S_READ;
          else                         state_nxt = S_TRIG;
        end
      end
      S_TRIG: state_nxt = S_HOLD;
      S_HOLD: if (cnt == HOLD_LAST) state_nxt = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (iFLASH_RY_N) state_nxt = (op == OP_ERASE) ? S_FIN : S_NEXT;
`ifdef FLASH_SWEEP_TMO_EN
        else if (tmo_last) state_nxt = S_FIN;
`endif
      end
      S_READ: if (cnt == READ_LAST) state_nxt = S_NEXT;
      // end = all-ones exits here before the increment, so the address never wraps
      S_NEXT: begin
        if (at_end)                 state_nxt = S_FIN;
        else if (op == OP_VERIFY)   state_nxt = S_READ;
        else                        state_nxt = S_TRIG;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_now) state_nxt = S_FIN;
  end

  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      op        <= OP_VERIFY;
      addr      <= '0;
      end_addr  <= '0;
      cnt       <= '0;
      flash_cmd <= FC_IDLE;
      fail      <= 1'b0;
      err_cnt   <= '0;
      err_addr  <= '0;
    end else begin
      if ((state == S_HOLD || state == S_READ) && state_nxt == state)
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;

      if (accept) begin
        op       <= op_t'(iCMD);
        addr     <= (iCMD == OP_ERASE) ? '0 : iSTART_ADDR;
        end_addr <= iEND_ADDR;
        fail     <= reject;
        err_cnt  <= '0;
        err_addr <= '0;
        case (iCMD)
          OP_VERIFY:  flash_cmd <= FC_READ;
          OP_PROGRAM: flash_cmd <= FC_PROG;
          OP_ERASE:   flash_cmd <= FC_ERASE;
          default:    flash_cmd <= FC_IDLE;
        endcase
      end else begin
        if (state == S_FIN) flash_cmd <= FC_IDLE;
        if (state == S_NEXT && state_nxt != S_FIN) addr <= addr + ADDR_W'(1);
        if (abort_now || mismatch) fail <= 1'b1;
`ifdef FLASH_SWEEP_TMO_EN
        if (state == S_WAIT_RDY && !iFLASH_RY_N && tmo_last) fail <= 1'b1;
`endif
        if (mismatch) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
          if (err_cnt == '0) err_addr <= addr;
        end
      end
    end
  end

`ifdef FLASH_SWEEP_TMO_EN
  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N)                                         tmo_cnt <= '0;
    else if (state == S_WAIT_RDY && state_nxt == S_WAIT_RDY) tmo_cnt <= tmo_cnt + TMO_W'(1);
    else                                                   tmo_cnt <= '0;
  end
`endif

  assign oCMD_READY  = (state == S_IDLE);
  assign oBUSY       = (state != S_IDLE);
  assign oDONE       = (state == S_FIN);
  assign oFLASH_TR   = ((state == S_TRIG) || (state == S_READ)) && !iABORT;
  assign oFLASH_ADDR = addr;
  assign oFLASH_CMD  = flash_cmd;
  assign oFAIL       = fail;
  assign oERR_CNT    = err_cnt;
  assign oERR_ADDR   = err_addr;

endmodule

// File: tb/tb_flash_sweep_ctrl.sv
// Directed self-checking bench for flash_sweep_ctrl (PROG_DIV = 4, READ_DIV = 4, TMO_CYC = 50).
module tb_flash_sweep_ctrl;

  logic        iCLK = 1'b0;
  logic        iRESET_N = 1'b0;
  logic        iCMD_VALID = 1'b0;
  logic [1:0]  iCMD = 2'd0;
  logic        oCMD_READY;
  logic [21:0] iSTART_ADDR = '0;
  logic [21:0] iEND_ADDR = '0;
  logic        iABORT = 1'b0;
  logic        iFLASH_RY_N = 1'b1;
  logic [15:0] iFLASH_DQ, iEXP_DQ;
  logic [21:0] oFLASH_ADDR;
  logic [3:0]  oFLASH_CMD;
  logic        oFLASH_TR, oBUSY, oDONE, oFAIL;
  logic [15:0] oERR_CNT;
  logic [21:0] oERR_ADDR;

  int checks = 0;
  int errors = 0;

  int          n_rise, first_fall, done_idx, done_cnt;
  int          rise_idx [16];
  logic [21:0] rise_addr [16];
  logic [21:0] addr_at_done;
  logic        fail_at_done;

  flash_sweep_ctrl #(
    .ADDR_W(22), .DATA_W(16), .PROG_DIV(4), .READ_DIV(4), .TMO_CYC(50)
  ) dut (
    .iCLK(iCLK), .iRESET_N(iRESET_N), .iCMD_VALID(iCMD_VALID), .iCMD(iCMD),
    .oCMD_READY(oCMD_READY), .iSTART_ADDR(iSTART_ADDR), .iEND_ADDR(iEND_ADDR),
    .iABORT(iABORT), .iFLASH_RY_N(iFLASH_RY_N), .iFLASH_DQ(iFLASH_DQ), .iEXP_DQ(iEXP_DQ),
    .oFLASH_ADDR(oFLASH_ADDR), .oFLASH_CMD(oFLASH_CMD), .oFLASH_TR(oFLASH_TR),
    .oBUSY(oBUSY), .oDONE(oDONE), .oFAIL(oFAIL), .oERR_CNT(oERR_CNT), .oERR_ADDR(oERR_ADDR)
  );

  always #5 iCLK = ~iCLK;

  // Flash model: expected data = address, stored data corrupted at address 5.
  always_comb begin
    iEXP_DQ   = 16'(oFLASH_ADDR);
    iFLASH_DQ = (oFLASH_ADDR == 22'd5) ? 16'hBEEF : 16'(oFLASH_ADDR);
  end

  // Called at a negedge with the DUT idle; returns at the first negedge after the accept edge.
  task automatic issue(input logic [1:0] c, input logic [21:0] s, input logic [21:0] e);
    iCMD_VALID  = 1'b1;
    iCMD        = c;
    iSTART_ADDR = s;
    iEND_ADDR   = e;
    @(negedge iCLK);
    iCMD_VALID  = 1'b0;
  endtask

  // Records trigger edges and the done pulse, sample 0 being the current negedge.
  // Returns one negedge after oDONE, or after budget samples.
  task automatic run_watch(input int budget);
    logic prev;
    prev = 1'b0; n_rise = 0; first_fall = -1; done_idx = -1; done_cnt = 0;
    for (int k = 0; k < budget; k++) begin
      if (oFLASH_TR && !prev) begin
        if (n_rise < 16) begin rise_idx[n_rise] = k; rise_addr[n_rise] = oFLASH_ADDR; end
        n_rise++;
      end
      if (!oFLASH_TR && prev && first_fall < 0) first_fall = k;
      if (oDONE) begin
        done_cnt++;
        if (done_idx < 0) begin done_idx = k; addr_at_done = oFLASH_ADDR; fail_at_done = oFAIL; end
      end
      prev = oFLASH_TR;
      @(negedge iCLK);
      if (done_idx >= 0) break;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++; if (oFLASH_CMD !== 4'd7) begin errors++; $display("FAIL rst_cmd got %0h want 7", oFLASH_CMD); end
    checks++; if (oCMD_READY !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", oCMD_READY); end
    checks++; if (oFLASH_ADDR !== 22'd0) begin errors++; $display("FAIL rst_addr got %0h want 0", oFLASH_ADDR); end
    checks++; if ({oFLASH_TR, oBUSY, oDONE, oFAIL} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b want 0000", {oFLASH_TR, oBUSY, oDONE, oFAIL}); end
    checks++; if (oERR_CNT !== 16'd0) begin errors++; $display("FAIL rst_errcnt got %0h want 0", oERR_CNT); end
    checks++; if (oERR_ADDR !== 22'd0) begin errors++; $display("FAIL rst_erraddr got %0h want 0", oERR_ADDR); end
    @(negedge iCLK);
    iRESET_N = 1'b1;
    @(negedge iCLK);
    checks++; if ({oCMD_READY, oBUSY, oDONE} !== 3'b100) begin errors++; $display("FAIL idle_flags got %b want 100", {oCMD_READY, oBUSY, oDONE}); end
  endtask

  task automatic test_program;
    iFLASH_RY_N = 1'b1;
    issue(2'd1, 22'h10, 22'h13);
    checks++; if ({oBUSY, oCMD_READY, oFLASH_TR} !== 3'b101) begin errors++; $display("FAIL prog_accept got %b want 101", {oBUSY, oCMD_READY, oFLASH_TR}); end
    checks++; if (oFLASH_CMD !== 4'd1) begin errors++; $display("FAIL prog_cmd got %0h want 1", oFLASH_CMD); end
    run_watch(60);
    checks++; if (n_rise !== 4) begin errors++; $display("FAIL prog_ntr got %0d want 4", n_rise); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rise_idx[i] !== 6 * i) begin errors++; $display("FAIL prog_tr_time[%0d] got %0d want %0d", i, rise_idx[i], 6 * i); end
      checks++; if (rise_addr[i] !== 22'h10 + 22'(i)) begin errors++; $display("FAIL prog_tr_addr[%0d] got %0h want %0h", i, rise_addr[i], 22'h10 + 22'(i)); end
    end
    checks++; if (done_idx !== 24) begin errors++; $display("FAIL prog_done_time got %0d want 24", done_idx); end
    checks++; if (fail_at_done !== 1'b0) begin errors++; $display("FAIL prog_fail got %b want 0", fail_at_done); end
    checks++; if ({oDONE, oCMD_READY, oBUSY} !== 3'b010) begin errors++; $display("FAIL prog_after got %b want 010", {oDONE, oCMD_READY, oBUSY}); end
    checks++; if (oFLASH_CMD !== 4'd7) begin errors++; $display("FAIL prog_cmd_idle got %0h want 7", oFLASH_CMD); end
  endtask

  task automatic test_verify;
    issue(2'd0, 22'd0, 22'd7);
    checks++; if (oFLASH_CMD !== 4'd0) begin errors++; $display("FAIL ver_cmd got %0h want 0", oFLASH_CMD); end
    run_watch(80);
    checks++; if (n_rise !== 8) begin errors++; $display("FAIL ver_nread got %0d want 8", n_rise); end
    checks++; if (rise_idx[7] !== 35) begin errors++; $display("FAIL ver_last_read got %0d want 35", rise_idx[7]); end
    checks++; if (done_idx - first_fall !== 36) begin errors++; $display("FAIL ver_done_time got %0d want 36", done_idx - first_fall); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ver_ndone got %0d want 1", done_cnt); end
    checks++; if (oERR_CNT !== 16'd1) begin errors++; $display("FAIL ver_errcnt got %0h want 1", oERR_CNT); end
    checks++; if (oERR_ADDR !== 22'd5) begin errors++; $display("FAIL ver_erraddr got %0h want 5", oERR_ADDR); end
    checks++; if (oFAIL !== 1'b1) begin errors++; $display("FAIL ver_fail got %b want 1", oFAIL); end
  endtask

  task automatic test_erase;
    int n_tr, early;
    n_tr = 1; early = 0;
    iFLASH_RY_N = 1'b0;
    issue(2'd2, 22'h123, 22'h456);
    checks++; if ({oFLASH_TR, oFAIL} !== 2'b10) begin errors++; $display("FAIL ers_accept got %b want 10", {oFLASH_TR, oFAIL}); end
    checks++; if (oFLASH_ADDR !== 22'd0) begin errors++; $display("FAIL ers_addr got %0h want 0", oFLASH_ADDR); end
    checks++; if (oERR_CNT !== 16'd0) begin errors++; $display("FAIL ers_errcnt_clr got %0h want 0", oERR_CNT); end
    checks++; if (oFLASH_CMD !== 4'd4) begin errors++; $display("FAIL ers_cmd got %0h want 4", oFLASH_CMD); end
`ifdef FLASH_SWEEP_TMO_EN
    for (int k = 1; k <= 53; k++) begin
      @(negedge iCLK);
      if (oFLASH_TR) n_tr++;
      if (oDONE) early++;
    end
    @(negedge iCLK);
    checks++; if ({oDONE, oFAIL} !== 2'b11) begin errors++; $display("FAIL ers_tmo got %b want 11", {oDONE, oFAIL}); end
    iFLASH_RY_N = 1'b1;
`else
    for (int k = 1; k <= 103; k++) begin
      @(negedge iCLK);
      if (oFLASH_TR) n_tr++;
      if (oDONE) early++;
    end
    checks++; if (oBUSY !== 1'b1) begin errors++; $display("FAIL ers_wait_busy got %b want 1", oBUSY); end
    iFLASH_RY_N = 1'b1;
    @(negedge iCLK);
    checks++; if ({oDONE, oFAIL} !== 2'b10) begin errors++; $display("FAIL ers_done got %b want 10", {oDONE, oFAIL}); end
`endif
    checks++; if (n_tr !== 1) begin errors++; $display("FAIL ers_ntr got %0d want 1", n_tr); end
    checks++; if (early !== 0) begin errors++; $display("FAIL ers_early_done got %0d want 0", early); end
    @(negedge iCLK);
  endtask

  task automatic test_abort;
    issue(2'd1, 22'h10, 22'h13);
    repeat (6) @(negedge iCLK);
    checks++; if ({oFLASH_TR, oFLASH_ADDR} !== {1'b1, 22'h11}) begin errors++; $display("FAIL abt_pre got %b/%0h want 1/11", oFLASH_TR, oFLASH_ADDR); end
    iABORT = 1'b1;
    #1;
    checks++; if (oFLASH_TR !== 1'b0) begin errors++; $display("FAIL abt_tr_forced got %b want 0", oFLASH_TR); end
    @(negedge iCLK);
    iABORT = 1'b0;
    checks++; if ({oDONE, oFAIL} !== 2'b11) begin errors++; $display("FAIL abt_done got %b want 11", {oDONE, oFAIL}); end
    checks++; if (oFLASH_ADDR !== 22'h11) begin errors++; $display("FAIL abt_addr got %0h want 11", oFLASH_ADDR); end
    @(negedge iCLK);
    checks++; if ({oCMD_READY, oDONE, oFAIL} !== 3'b101) begin errors++; $display("FAIL abt_after got %b want 101", {oCMD_READY, oDONE, oFAIL}); end
  endtask

  task automatic test_reject;
    issue(2'd0, 22'd5, 22'd3);
    checks++; if ({oDONE, oFAIL, oFLASH_TR} !== 3'b110) begin errors++; $display("FAIL rej_done got %b want 110", {oDONE, oFAIL, oFLASH_TR}); end
    @(negedge iCLK);
    checks++; if ({oCMD_READY, oDONE} !== 2'b10) begin errors++; $display("FAIL rej_after got %b want 10", {oCMD_READY, oDONE}); end
    issue(2'd3, 22'd0, 22'd1);
    checks++; if ({oDONE, oFAIL, oFLASH_TR} !== 3'b110) begin errors++; $display("FAIL rsvd_done got %b want 110", {oDONE, oFAIL, oFLASH_TR}); end
    @(negedge iCLK);
  endtask

  task automatic test_top_window;
    issue(2'd1, 22'h3FFFFE, 22'h3FFFFF);
    run_watch(40);
    checks++; if (n_rise !== 2) begin errors++; $display("FAIL top_ntr got %0d want 2", n_rise); end
    checks++; if (rise_addr[1] !== 22'h3FFFFF) begin errors++; $display("FAIL top_addr1 got %0h want 3fffff", rise_addr[1]); end
    checks++; if (done_idx !== 12) begin errors++; $display("FAIL top_done_time got %0d want 12", done_idx); end
    checks++; if (addr_at_done !== 22'h3FFFFF) begin errors++; $display("FAIL top_nowrap got %0h want 3fffff", addr_at_done); end
    checks++; if (fail_at_done !== 1'b0) begin errors++; $display("FAIL top_fail got %b want 0", fail_at_done); end
  endtask

  task automatic test_reset_mid;
    issue(2'd0, 22'd0, 22'd7);
    repeat (7) @(negedge iCLK);
    #2 iRESET_N = 1'b0;
    #1;
    checks++; if ({oCMD_READY, oBUSY, oDONE, oFLASH_TR} !== 4'b1000) begin errors++; $display("FAIL mrst_flags got %b want 1000", {oCMD_READY, oBUSY, oDONE, oFLASH_TR}); end
    checks++; if ({oFLASH_CMD, oFLASH_ADDR} !== {4'd7, 22'd0}) begin errors++; $display("FAIL mrst_cmd_addr got %0h/%0h want 7/0", oFLASH_CMD, oFLASH_ADDR); end
    @(negedge iCLK);
    iRESET_N = 1'b1;
    @(negedge iCLK);
    checks++; if ({oCMD_READY, oDONE} !== 2'b10) begin errors++; $display("FAIL mrst_after got %b want 10", {oCMD_READY, oDONE}); end
  endtask

  initial begin
    test_reset;
    test_program;
    test_verify;
    test_erase;
    test_abort;
    test_reject;
    test_top_window;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
